mmio_bus_arbiter: RTL and testbench

Two-requester arbiter that shares the single MMIO device bus (switches, LEDs, seg7, ROM aggregator) between master 0 (CPU data port) and master 1 (secondary master, e.g. debug/DMA). It grants round-robin, drives the bus from registered copies of the winning request, and waits for the device done. It returns a one-cycle done with registered read data, and aborts with an error after a programmable timeout. It sits between the masters and the MMIO device aggregator.

---
 rtl/mmio_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_mmio_bus_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_arbiter.sv
// Round-robin arbiter sharing one MMIO device bus between two masters.
// Winning request is registered onto the bus; completion or timeout returns a one-cycle done.
module mmio_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          CNT_W          = 8,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mmio_read,
  output logic        mmio_write,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_write_data,
  input  logic        mmio_done,
  input  logic [31:0] mmio_read_data,
  output logic        busy,
  output logic        owner,
  output logic [1:0]  state_dbg
);

  // Handshake: a master holds read/write (level) until its one-cycle done and
  // drops it the cycle after; the device answers with a combinational mmio_done.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;

  logic        m0_pend, m1_pend, grant_valid, grant;
  logic        sel_read, sel_write;
  logic [31:0] sel_addr, sel_wdata;
  logic        timeout_hit, finish;
  logic [31:0] done_rdata;

  always_comb begin
    m0_pend     = m0_read | m0_write;
    m1_pend     = m1_read | m1_write;
    grant_valid = m0_pend | m1_pend;
    grant       = (m0_pend && m1_pend) ? ~last_grant : m1_pend;
    sel_read    = grant ? m1_read  : m0_read;
    sel_write   = grant ? m1_write : m0_write;
    sel_addr    = grant ? m1_addr  : m0_addr;
    sel_wdata   = grant ? m1_wdata : m0_wdata;
    timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    finish      = mmio_done | timeout_hit;
    done_rdata  = mmio_done ? mmio_read_data : ERR_RDATA;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = BUSY;
      BUSY:    if (finish)      state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mmio_read       <= 1'b0;
      mmio_write      <= 1'b0;
      mmio_addr       <= '0;
      mmio_write_data <= '0;
      m0_done         <= 1'b0;
      m0_rdata        <= '0;
      m0_err          <= 1'b0;
      m1_done         <= 1'b0;
      m1_rdata        <= '0;
      m1_err          <= 1'b0;
      owner           <= 1'b0;
      last_grant      <= 1'b1;
      cnt             <= '0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner           <= grant;
            last_grant      <= grant;
            cnt             <= '0;
            mmio_addr       <= sel_addr;
            mmio_write_data <= sel_wdata;
            mmio_write      <= sel_write;
            // A simultaneous read+write is issued as a write only.
            mmio_read       <= sel_read & ~sel_write;
          end
        end
        BUSY: begin
          if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
          if (finish) begin
            mmio_read  <= 1'b0;
            mmio_write <= 1'b0;
            if (owner) begin
              m1_done  <= 1'b1;
              m1_rdata <= done_rdata;
              m1_err   <= ~mmio_done;
            end else begin
              m0_done  <= 1'b1;
              m0_rdata <= done_rdata;
              m0_err   <= ~mmio_done;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Self-checking bench for mmio_bus_arbiter: scoreboard of expected completions
// against a simple latency-programmable device model.
module tb_mmio_bus_arbiter;

  localparam logic [31:0] ERR = 32'h0000_0000;
  localparam logic [31:0] K   = 32'h5A5A_0000;

  logic        sys_clk, rst_n;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mmio_read, mmio_write, mmio_done;
  logic [31:0] mmio_addr, mmio_write_data, mmio_read_data;
  logic        busy, owner;
  logic [1:0]  state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  logic [33:0] exp_q[$];   // {master, err, rdata}

  // Device model: done in bus cycle dev_lat (0 = never answers).
  int          dev_lat;
  logic [31:0] dev_data;
  bit          use_addr_data;
  int          bus_cyc;
  int          m0_pulses = 0;
  int          m1_pulses = 0;

  mmio_bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8), .ERR_RDATA(ERR)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mmio_read(mmio_read), .mmio_write(mmio_write), .mmio_addr(mmio_addr),
    .mmio_write_data(mmio_write_data), .mmio_done(mmio_done),
    .mmio_read_data(mmio_read_data), .busy(busy), .owner(owner), .state_dbg(state_dbg)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                       bus_cyc <= 1;
    else if (mmio_read || mmio_write) bus_cyc <= bus_cyc + 1;
    else                              bus_cyc <= 1;
  end

  assign mmio_done      = (mmio_read || mmio_write) && (dev_lat != 0) && (bus_cyc == dev_lat);
  assign mmio_read_data = use_addr_data ? (mmio_addr ^ K) : dev_data;

  always @(negedge sys_clk) begin
    if (m0_done) m0_pulses++;
    if (m1_done) m1_pulses++;
  end

  // driver tasks
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic wait_done(output bit seen, output logic [33:0] got, output int cyc,
                           output int rdc, output int wrc, output logic [31:0] a,
                           output logic [31:0] wd, output logic act, output logic bsy);
    seen = 0; got = 'x; cyc = 0; rdc = 0; wrc = 0; a = 'x; wd = 'x; act = 1'bx; bsy = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (m0_done || m1_done) begin
        seen = 1;
        cyc  = i + 1;
        got  = {m1_done, (m1_done ? m1_err : m0_err), (m1_done ? m1_rdata : m0_rdata)};
        act  = mmio_read | mmio_write;
        bsy  = busy;
        return;
      end
      if (mmio_read)  rdc++;
      if (mmio_write) wrc++;
      if (mmio_read || mmio_write) begin
        a  = mmio_addr;
        wd = mmio_write_data;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({mmio_read, mmio_write, mmio_addr, mmio_write_data, m0_done, m0_rdata, m0_err,
         m1_done, m1_rdata, m1_err, busy, owner} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rd=%b wr=%b addr=%h busy=%b owner=%b, required all 0",
               mmio_read, mmio_write, mmio_addr, busy, owner);
    end
    tests_run++;
    if (state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d required 0", state_dbg);
    end
  endtask

  task automatic test_single_read();
    bit seen; logic [33:0] got, exp; int cyc, rdc, wrc; logic [31:0] a, wd; logic act, bsy;
    int m1_snap;
    use_addr_data = 0; dev_lat = 2; dev_data = 32'h00A5_5A00;
    m1_snap = m1_pulses;
    m0_addr = 32'hFFFF_0000; m0_read = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'h00A5_5A00});
    wait_done(seen, got, cyc, rdc, wrc, a, wd, act, bsy);
    m0_read = 1'b0;
    tests_run++;
    if (!seen || exp_q.size() == 0) begin
      tests_failed++; $display("FAIL single_done: no done within bound");
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        tests_failed++; $display("FAIL single_result: got %h required %h", got, exp);
      end
    end
    tests_run++;
    if (cyc !== 3 || rdc !== 2 || wrc !== 0) begin
      tests_failed++;
      $display("FAIL single_timing: cyc=%0d rd=%0d wr=%0d required 3/2/0", cyc, rdc, wrc);
    end
    tests_run++;
    if (a !== 32'hFFFF_0000) begin
      tests_failed++; $display("FAIL single_addr: got %h required ffff0000", a);
    end
    tests_run++;
    if (act !== 1'b0 || bsy !== 1'b1 || state_dbg !== 2'd2) begin
      tests_failed++;
      $display("FAIL single_release: bus=%b busy=%b state=%0d required 0/1/2", act, bsy, state_dbg);
    end
    @(negedge sys_clk);
    tests_run++;
    if (m0_done !== 1'b0 || busy !== 1'b0 || m1_pulses !== m1_snap || m0_rdata !== 32'h00A5_5A00) begin
      tests_failed++;
      $display("FAIL single_after: done=%b busy=%b m1_pulses=%0d rdata=%h required 0/0/%0d/00a55a00",
               m0_done, busy, m1_pulses, m0_rdata, m1_snap);
    end
  endtask

  task automatic test_contention();
    bit seen; logic [33:0] got, exp; int cyc, rdc, wrc; logic [31:0] a, wd; logic act, bsy;
    apply_reset();
    use_addr_data = 1; dev_lat = 1;
    m0_addr = 32'h100; m0_wdata = 32'hDEAD; m1_addr = 32'h200; m1_wdata = 32'h0;
    m0_write = 1'b1; m1_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_q.push_back({1'b0, 1'b0, 32'h100 ^ K});
      else            exp_q.push_back({1'b1, 1'b0, 32'h200 ^ K});
    end
    for (int i = 0; i < 4; i++) begin
      wait_done(seen, got, cyc, rdc, wrc, a, wd, act, bsy);
      if (i == 3) begin m0_write = 1'b0; m1_read = 1'b0; end
      tests_run++;
      if (!seen || exp_q.size() == 0) begin
        tests_failed++; $display("FAIL contention_done_%0d: no done within bound", i);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          tests_failed++; $display("FAIL contention_result_%0d: got %h required %h", i, got, exp);
        end
      end
      tests_run++;
      if (cyc !== ((i == 0) ? 2 : 3) || rdc !== ((i % 2 == 1) ? 1 : 0) || wrc !== ((i % 2 == 0) ? 1 : 0)) begin
        tests_failed++;
        $display("FAIL contention_bus_%0d: cyc=%0d rd=%0d wr=%0d", i, cyc, rdc, wrc);
      end
      tests_run++;
      if (a !== ((i % 2 == 0) ? 32'h100 : 32'h200) || ((i % 2 == 0) && wd !== 32'hDEAD)) begin
        tests_failed++;
        $display("FAIL contention_addr_%0d: addr=%h wdata=%h", i, a, wd);
      end
    end
    @(negedge sys_clk);
  endtask

  task automatic test_timeout();
    bit seen; logic [33:0] got, exp; int cyc, rdc, wrc; logic [31:0] a, wd; logic act, bsy;
    use_addr_data = 0; dev_data = 32'hCAFE_F00D; dev_lat = 0;
    m1_addr = 32'hFFFF_F000; m1_read = 1'b1;
    exp_q.push_back({1'b1, 1'b1, ERR});
    wait_done(seen, got, cyc, rdc, wrc, a, wd, act, bsy);
    m1_read = 1'b0;
    tests_run++;
    if (!seen || exp_q.size() == 0) begin
      tests_failed++; $display("FAIL timeout_done: no done within bound");
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        tests_failed++; $display("FAIL timeout_result: got %h required %h", got, exp);
      end
    end
    tests_run++;
    if (cyc !== 5 || rdc !== 4 || act !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_timing: cyc=%0d rd=%0d bus=%b required 5/4/0", cyc, rdc, act);
    end
    tests_run++;
    if (m0_rdata !== (32'h100 ^ K) || m0_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_other_master: rdata=%h err=%b required %h/0", m0_rdata, m0_err, 32'h100 ^ K);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_done_at_timeout();
    bit seen; logic [33:0] got, exp; int cyc, rdc, wrc; logic [31:0] a, wd; logic act, bsy;
    dev_lat = 4; dev_data = 32'h0000_1234;
    m0_addr = 32'h40; m0_read = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'h0000_1234});
    wait_done(seen, got, cyc, rdc, wrc, a, wd, act, bsy);
    m0_read = 1'b0;
    tests_run++;
    if (!seen || exp_q.size() == 0) begin
      tests_failed++; $display("FAIL coincide_done: no done within bound");
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        tests_failed++; $display("FAIL coincide_result: got %h required %h", got, exp);
      end
    end
    tests_run++;
    if (cyc !== 5 || rdc !== 4 || m1_err !== 1'b1 || m1_rdata !== ERR) begin
      tests_failed++;
      $display("FAIL coincide_timing: cyc=%0d rd=%0d m1_err=%b m1_rdata=%h", cyc, rdc, m1_err, m1_rdata);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_rw_both();
    bit seen; logic [33:0] got, exp; int cyc, rdc, wrc; logic [31:0] a, wd; logic act, bsy;
    dev_lat = 1; dev_data = 32'h77;
    m0_addr = 32'hFFFF_0080; m0_wdata = 32'hFF; m0_read = 1'b1; m0_write = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'h77});
    wait_done(seen, got, cyc, rdc, wrc, a, wd, act, bsy);
    m0_read = 1'b0; m0_write = 1'b0;
    tests_run++;
    if (!seen || exp_q.size() == 0) begin
      tests_failed++; $display("FAIL rw_done: no done within bound");
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        tests_failed++; $display("FAIL rw_result: got %h required %h", got, exp);
      end
    end
    tests_run++;
    if (wrc !== 1 || rdc !== 0 || a !== 32'hFFFF_0080 || wd !== 32'hFF) begin
      tests_failed++;
      $display("FAIL rw_bus: wr=%0d rd=%0d addr=%h wdata=%h required 1/0/ffff0080/ff", wrc, rdc, a, wd);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_reset_mid_busy();
    bit seen; logic [33:0] got, exp; int cyc, rdc, wrc; logic [31:0] a, wd; logic act, bsy;
    int m1_snap;
    dev_lat = 0; m1_addr = 32'h300; m1_read = 1'b1;
    repeat (2) @(negedge sys_clk);
    tests_run++;
    if (mmio_read !== 1'b1 || owner !== 1'b1) begin
      tests_failed++; $display("FAIL midbusy_pre: rd=%b owner=%b required 1/1", mmio_read, owner);
    end
    m1_snap = m1_pulses;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({mmio_read, mmio_write, mmio_addr, mmio_write_data, m0_done, m0_rdata, m0_err,
         m1_done, m1_rdata, m1_err, busy, owner} !== '0) begin
      tests_failed++;
      $display("FAIL midbusy_reset: rd=%b addr=%h m1_rdata=%h busy=%b required all 0",
               mmio_read, mmio_addr, m1_rdata, busy);
    end
    m1_read = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
    tests_run++;
    if (m1_pulses !== m1_snap) begin
      tests_failed++; $display("FAIL midbusy_nodone: pulses=%0d required %0d", m1_pulses, m1_snap);
    end
    use_addr_data = 1; dev_lat = 1;
    m0_addr = 32'h400; m1_addr = 32'h500; m0_read = 1'b1; m1_read = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'h400 ^ K});
    exp_q.push_back({1'b1, 1'b0, 32'h500 ^ K});
    for (int i = 0; i < 2; i++) begin
      wait_done(seen, got, cyc, rdc, wrc, a, wd, act, bsy);
      if (i == 0) m0_read = 1'b0; else m1_read = 1'b0;
      tests_run++;
      if (!seen || exp_q.size() == 0) begin
        tests_failed++; $display("FAIL midbusy_fresh_done_%0d: no done within bound", i);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          tests_failed++; $display("FAIL midbusy_fresh_%0d: got %h required %h", i, got, exp);
        end
      end
    end
    @(negedge sys_clk);
    tests_run++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL final_drain: queue=%0d busy=%b required 0/0", exp_q.size(), busy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m0_read = 0; m0_write = 0; m0_addr = 0; m0_wdata = 0;
    m1_read = 0; m1_write = 0; m1_addr = 0; m1_wdata = 0;
    dev_lat = 1; dev_data = 0; use_addr_data = 0;
    test_reset();
    test_single_read();
    test_contention();
    test_timeout();
    test_done_at_timeout();
    test_rw_both();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
